// File: rtl/sram_cache_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_cache_controller_if                                      |
// | Purpose  : Bus bundle between the memory stage, the word cache and the   |
// |            sram_controller. Carries the CPU-side enable/ready handshake  |
// |            and the SRAM-side request/response signals.                   |
// | Modports : slave  - cache controller view                                |
// |            master - requester / SRAM-model view                          |
// | Signals  : r_en_in, w_en_in, address_in[31:0], write_data_in[31:0]       |
// |            read_data_out[31:0], ready_out                                |
// |            sram_r_en_out, sram_w_en_out, sram_address_out[31:0],         |
// |            sram_write_data_out[31:0], sram_read_data_in[31:0],           |
// |            sram_ready_in                                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface sram_cache_controller_if;
  logic        r_en_in;
  logic        w_en_in;
  logic [31:0] address_in;
  logic [31:0] write_data_in;
  logic [31:0] read_data_out;
  logic        ready_out;
  logic        sram_r_en_out;
  logic        sram_w_en_out;
  logic [31:0] sram_address_out;
  logic [31:0] sram_write_data_out;
  logic [31:0] sram_read_data_in;
  logic        sram_ready_in;

  modport slave (
    input  r_en_in, w_en_in, address_in, write_data_in,
    input  sram_read_data_in, sram_ready_in,
    output read_data_out, ready_out,
    output sram_r_en_out, sram_w_en_out, sram_address_out, sram_write_data_out
  );

  modport master (
    output r_en_in, w_en_in, address_in, write_data_in,
    output sram_read_data_in, sram_ready_in,
    input  read_data_out, ready_out,
    input  sram_r_en_out, sram_w_en_out, sram_address_out, sram_write_data_out
  );
endinterface
`default_nettype wire

// File: rtl/sram_cache_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_cache_controller                                         |
// | Purpose  : Direct-mapped, write-through, no-write-allocate word cache    |
// |            placed in front of sram_controller. Read hits complete in the |
// |            request cycle; read misses and all writes stall until the     |
// |            SRAM signals ready.                                           |
// | Ports    : clk, rst (async, active-high)                                 |
// |            bus (sram_cache_controller_if.slave) - CPU and SRAM signals   |
// |            hit_count_out[15:0], miss_count_out[15:0] (stats build only)  |
// | Options  : SRAM_CACHE_STATS_EN - adds saturating hit/miss counters       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sram_cache_controller #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_BITS  = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  sram_cache_controller_if.slave    bus
`ifdef SRAM_CACHE_STATS_EN
  ,
  output logic [15:0]               hit_count_out,
  output logic [15:0]               miss_count_out
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] READ_MISS  = 2'd1;
  localparam logic [1:0] WRITE_THRU = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  // Lookup on the live CPU address (IDLE) and on the latched transaction
  // address (stalled states), which may differ while the CPU is stalled.
  logic [INDEX_BITS-1:0] cpu_idx, txn_idx;
  logic [TAG_BITS-1:0]   cpu_tag, txn_tag;
  logic                  cpu_hit, txn_hit;

  assign cpu_idx = bus.address_in[INDEX_BITS+1:2];
  assign cpu_tag = bus.address_in[ADDR_BITS+1:INDEX_BITS+2];
  assign txn_idx = addr_q[INDEX_BITS+1:2];
  assign txn_tag = addr_q[ADDR_BITS+1:INDEX_BITS+2];
  assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign txn_hit = valid_q[txn_idx] && (tag_q[txn_idx] == txn_tag);

  logic        ready;
  logic [31:0] rdata;
  logic        fill_en;
  logic        update_en;
  logic        hit_evt;
  logic        miss_evt;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ready     = 1'b0;
    rdata     = 32'h0;
    fill_en   = 1'b0;
    update_en = 1'b0;
    hit_evt   = 1'b0;
    miss_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        // A simultaneous read and write is treated as a write.
        if (bus.w_en_in) begin
          state_d = WRITE_THRU;
          addr_d  = {bus.address_in[31:2], 2'b00};
          wdata_d = bus.write_data_in;
        end else if (bus.r_en_in) begin
          if (cpu_hit) begin
            ready   = 1'b1;
            rdata   = data_q[cpu_idx];
            hit_evt = 1'b1;
          end else begin
            state_d  = READ_MISS;
            addr_d   = {bus.address_in[31:2], 2'b00};
            miss_evt = 1'b1;
          end
        end
      end
      READ_MISS: begin
        if (bus.sram_ready_in) begin
          ready   = 1'b1;
          rdata   = bus.sram_read_data_in;
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE_THRU: begin
        if (bus.sram_ready_in) begin
          ready     = 1'b1;
          update_en = txn_hit;  // no allocation on a write miss
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready_out           = ready;
  assign bus.read_data_out       = rdata;
  assign bus.sram_r_en_out       = (state_q == READ_MISS);
  assign bus.sram_w_en_out       = (state_q == WRITE_THRU);
  assign bus.sram_address_out    = addr_q;
  assign bus.sram_write_data_out = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (fill_en) valid_q[txn_idx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset: valid_q gates every use, and fill/update
  // can only fire outside reset because reset forces state_q to IDLE.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[txn_idx]  <= txn_tag;
      data_q[txn_idx] <= bus.sram_read_data_in;
    end else if (update_en) begin
      data_q[txn_idx] <= wdata_q;
    end
  end

`ifdef SRAM_CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= 16'h0;
      miss_cnt_q <= 16'h0;
    end else begin
      if (hit_evt && (hit_cnt_q != 16'hFFFF))   hit_cnt_q  <= hit_cnt_q + 16'h1;
      if (miss_evt && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'h1;
    end
  end

  assign hit_count_out  = hit_cnt_q;
  assign miss_count_out = miss_cnt_q;
`else
  // Event strobes only feed the optional counters.
  logic unused_evt;
  assign unused_evt = hit_evt ^ miss_evt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_cache_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sram_cache_controller                                      |
// | Purpose  : Self-checking bench for sram_cache_controller: a latency-     |
// |            randomised SRAM model, a golden word memory and a reference   |
// |            cache directory that predicts hit/miss for every read.        |
// | Options  : SRAM_CACHE_STATS_EN - also checks the hit/miss counters       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sram_cache_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_cache_controller_if bus ();

`ifdef SRAM_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  sram_cache_controller #(.INDEX_BITS(6), .ADDR_BITS(18)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SRAM_CACHE_STATS_EN
    ,
    .hit_count_out  (hit_count),
    .miss_count_out (miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // SRAM model: ready pulses for one cycle after 'lat' extra wait cycles.
  logic [31:0] mem  [0:4095];
  logic [31:0] gold [0:4095];
  int          lat = 0;
  int          wcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sram_ready_in     <= 1'b0;
      bus.sram_read_data_in <= 32'h0;
      wcnt                  <= 0;
    end else begin
      bus.sram_ready_in <= 1'b0;
      if ((bus.sram_r_en_out || bus.sram_w_en_out) && !bus.sram_ready_in) begin
        if (wcnt >= lat) begin
          bus.sram_ready_in <= 1'b1;
          wcnt              <= 0;
          if (bus.sram_w_en_out)
            mem[bus.sram_address_out[13:2]] <= bus.sram_write_data_out;
          else
            bus.sram_read_data_in <= mem[bus.sram_address_out[13:2]];
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  // Reference directory: which word address each line currently holds.
  bit          ref_valid [64];
  int unsigned ref_word  [64];
  int          exp_hits = 0;
  int          exp_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] addr);
    int unsigned idx  = (addr >> 2) % 64;
    int unsigned word = (addr >> 2) % (1 << 18);
    bit          exp_hit = ref_valid[idx] && (ref_word[idx] == word);
    bit          done = 0;
    @(negedge clk);
    bus.r_en_in    = 1'b1;
    bus.w_en_in    = 1'b0;
    bus.address_in = addr;
    #1;
    if (exp_hit) begin
      exp_hits++;
      chk("hit_ready", bus.ready_out, 1);
      chk("hit_data", bus.read_data_out, gold[word[11:0]]);
      chk("hit_no_sram", bus.sram_r_en_out, 0);
      @(posedge clk);
    end else begin
      exp_miss++;
      chk("miss_ready0", bus.ready_out, 0);
      @(posedge clk);
      for (int n = 0; n < 20 && !done; n++) begin
        @(negedge clk);
        bus.address_in = $urandom;  // ignored while stalled
        #1;
        chk("miss_r_en", bus.sram_r_en_out, 1);
        chk("miss_addr", bus.sram_address_out, {addr[31:2], 2'b00});
        if (bus.ready_out) begin
          done = 1;
          chk("miss_data", bus.read_data_out, gold[word[11:0]]);
        end
        @(posedge clk);
      end
      if (!done) chk("miss_timeout", 0, 1);
      #1;
      chk("miss_en_drop", bus.sram_r_en_out, 0);
      ref_valid[idx] = 1;
      ref_word[idx]  = word;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input bit also_read);
    int unsigned word = (addr >> 2) % (1 << 18);
    bit          done = 0;
    @(negedge clk);
    bus.w_en_in       = 1'b1;
    bus.r_en_in       = also_read;
    bus.address_in    = addr;
    bus.write_data_in = data;
    #1;
    chk("wr_ready0", bus.ready_out, 0);
    @(posedge clk);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      bus.address_in    = $urandom;
      bus.write_data_in = $urandom;
      #1;
      chk("wr_w_en", bus.sram_w_en_out, 1);
      chk("wr_r_en0", bus.sram_r_en_out, 0);
      chk("wr_addr", bus.sram_address_out, {addr[31:2], 2'b00});
      chk("wr_data", bus.sram_write_data_out, data);
      if (bus.ready_out) done = 1;
      @(posedge clk);
    end
    if (!done) chk("wr_timeout", 0, 1);
    #1;
    chk("wr_en_drop", bus.sram_w_en_out, 0);
    gold[word[11:0]] = data;
    chk("sram_holds", mem[word[11:0]], data);
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.r_en_in = 1'b0;
    bus.w_en_in = 1'b0;
    #1;
    chk("idle_ready0", bus.ready_out, 0);
  endtask

  initial begin
    logic [31:0] a;
    rst                   = 1'b1;
    bus.r_en_in           = 1'b0;
    bus.w_en_in           = 1'b0;
    bus.address_in        = 32'h0;
    bus.write_data_in     = 32'h0;
    for (int i = 0; i < 4096; i++) begin
      gold[i] = $urandom;
      mem[i]  = gold[i];
    end
    gold[16] = 32'h3344_1122;
    mem[16]  = 32'h3344_1122;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", bus.ready_out, 0);
    chk("rst_rdata", bus.read_data_out, 0);
    chk("rst_r_en", bus.sram_r_en_out, 0);
    chk("rst_w_en", bus.sram_w_en_out, 0);
    chk("rst_addr", bus.sram_address_out, 0);
    chk("rst_wdata", bus.sram_write_data_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed sequence
    lat = 2;
    do_read(32'h0000_0040);
    do_read(32'h0000_0040);
    do_write(32'h0000_0040, 32'hDEAD_BEEF, 0);
    do_read(32'h0000_0040);
    do_write(32'h0000_0080, 32'h1234_5678, 0);
    do_read(32'h0000_0080);
    do_read(32'h0000_0140);
    do_read(32'h0000_0040);
    do_read(32'h0000_0140);
    do_read(32'h0000_0040);
    do_write(32'h0000_0044, 32'hCAFE_F00D, 1);
    go_idle();

`ifdef SRAM_CACHE_STATS_EN
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_miss);
`endif

    // Reset in the middle of a read miss (0x140 is not cached now)
    lat = 6;
    @(negedge clk);
    bus.r_en_in    = 1'b1;
    bus.address_in = 32'h0000_0140;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid_r_en", bus.sram_r_en_out, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_r_en", bus.sram_r_en_out, 0);
    chk("arst_w_en", bus.sram_w_en_out, 0);
    chk("arst_ready", bus.ready_out, 0);
`ifdef SRAM_CACHE_STATS_EN
    chk("arst_hits", hit_count, 0);
    chk("arst_miss", miss_count, 0);
`endif
    @(negedge clk);
    rst         = 1'b0;
    bus.r_en_in = 1'b0;
    for (int i = 0; i < 64; i++) ref_valid[i] = 0;
    exp_hits = 0;
    exp_miss = 0;
    lat = 1;
    do_read(32'h0000_0140);
    do_read(32'h0000_0040);

    // Randomised traffic over a small address pool to force hits and conflicts
    for (int n = 0; n < 120; n++) begin
      a = {18'h0, 4'($urandom_range(0, 3) * 5), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      lat = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0)
        do_write(a, $urandom, $urandom_range(0, 1) == 1);
      else
        do_read(a);
      if ($urandom_range(0, 4) == 0) go_idle();
    end
    go_idle();

`ifdef SRAM_CACHE_STATS_EN
    chk("final_hits", hit_count, exp_hits);
    chk("final_miss", miss_count, exp_miss);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
